// File: rtl/dsp_div_48x18.sv
`timescale 1ns/1ps
// Iterative signed divider (restoring, one quotient bit per clock) for MAC accumulator values.
// Optional macro DSP_DIV_ROUND_EN: round-half-away-from-zero quotient instead of truncation.
module dsp_div_48x18 #(
    parameter int DW = 48,
    parameter int VW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero,
    output logic          ovf
);

    localparam int CW = $clog2(DW);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [DW-1:0] QMAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] QMIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] CNT_TOP = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] shf_r;   // dividend magnitude shifting out, quotient bits shifting in
    logic [VW-1:0] rem_r;
    logic [VW-1:0] dsr_r;
    logic          sn_r;
    logic          sd_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [DW-1:0] quotient_r;
    logic [VW-1:0] remainder_r;
    logic          div_zero_r;
    logic          ovf_r;

    logic [VW:0]   trial_s;
    logic [VW:0]   diff_s;
    logic [VW-1:0] rem_nxt_s;
    logic          qbit_s;

    logic [DW:0]   qmag_s;
    logic [DW:0]   qlim_s;
    logic [VW-1:0] rmag_s;
    logic          rneg_s;
    logic          neg_q_s;
    logic          dz_s;
    logic          sat_s;
    logic [DW-1:0] q_fix_s;
    logic [VW-1:0] r_fix_s;
    logic          ovf_fix_s;

    // One restoring step: shift in the next dividend bit and try the subtraction.
    always_comb begin
        trial_s = {rem_r, shf_r[DW-1]};
        diff_s  = trial_s - {1'b0, dsr_r};
        if (diff_s[VW] == 1'b0) begin
            qbit_s    = 1'b1;
            rem_nxt_s = diff_s[VW-1:0];
        end else begin
            qbit_s    = 1'b0;
            rem_nxt_s = trial_s[VW-1:0];
        end
    end

    // Sign application, optional rounding and saturation of the final magnitudes.
    always_comb begin
        neg_q_s = sn_r ^ sd_r;
        dz_s    = (dsr_r == {VW{1'b0}});
`ifdef DSP_DIV_ROUND_EN
        if ({rem_r, 1'b0} >= {1'b0, dsr_r}) begin
            qmag_s = {1'b0, shf_r} + {{DW{1'b0}}, 1'b1};
            rmag_s = dsr_r - rem_r;
            rneg_s = ~sn_r;
        end else begin
            qmag_s = {1'b0, shf_r};
            rmag_s = rem_r;
            rneg_s = sn_r;
        end
`else
        qmag_s = {1'b0, shf_r};
        rmag_s = rem_r;
        rneg_s = sn_r;
`endif
        qlim_s = neg_q_s ? {1'b0, QMIN} : {1'b0, QMAX};
        sat_s  = (qmag_s > qlim_s);
        if (dz_s) begin
            q_fix_s   = sn_r ? QMIN : QMAX;
            r_fix_s   = {VW{1'b0}};
            ovf_fix_s = 1'b0;
        end else if (sat_s) begin
            q_fix_s   = neg_q_s ? QMIN : QMAX;
            r_fix_s   = {VW{1'b0}};
            ovf_fix_s = 1'b1;
        end else begin
            q_fix_s   = neg_q_s ? ({DW{1'b0}} - qmag_s[DW-1:0]) : qmag_s[DW-1:0];
            r_fix_s   = rneg_s ? ({VW{1'b0}} - rmag_s) : rmag_s;
            ovf_fix_s = 1'b0;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            shf_r       <= {DW{1'b0}};
            rem_r       <= {VW{1'b0}};
            dsr_r       <= {VW{1'b0}};
            sn_r        <= 1'b0;
            sd_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {VW{1'b0}};
            div_zero_r  <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        sn_r       <= dividend[DW-1];
                        sd_r       <= divisor[VW-1];
                        shf_r      <= dividend[DW-1] ? ({DW{1'b0}} - dividend) : dividend;
                        dsr_r      <= divisor[VW-1] ? ({VW{1'b0}} - divisor) : divisor;
                        rem_r      <= {VW{1'b0}};
                        cnt_r      <= CNT_TOP;
                        in_ready_r <= 1'b0;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    shf_r <= {shf_r[DW-2:0], qbit_s};
                    rem_r <= rem_nxt_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                FIX: begin
                    quotient_r  <= q_fix_s;
                    remainder_r <= r_fix_s;
                    div_zero_r  <= dz_s;
                    ovf_r       <= ovf_fix_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_dsp_div_48x18.sv
`timescale 1ns/1ps
// Directed bench for dsp_div_48x18: expected results queued at send time, popped on out_valid.
module tb_dsp_div_48x18;
    localparam int DW = 48;
    localparam int VW = 18;
    localparam longint QMAX = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint QMIN = -64'sh0000_8000_0000_0000;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        logic          ov;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = {DW{1'b0}};
    logic [VW-1:0] divisor = {VW{1'b0}};
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;
    logic          ovf;

    dsp_div_48x18 #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input longint q, input longint r, input logic dz, input logic ov);
        exp_t e;
        e.q  = q[DW-1:0];
        e.r  = r[VW-1:0];
        e.dz = dz;
        e.ov = ov;
        return e;
    endfunction

    // Reference built on the language's own / and %, plus the documented corner cases.
    function automatic exp_t model(input longint a, input longint b);
        longint q;
        longint r;
        logic   ov;
`ifdef DSP_DIV_ROUND_EN
        longint ab;
        longint ar;
`endif
        if (b == 64'sd0) begin
            return mk((a >= 64'sd0) ? QMAX : QMIN, 64'sd0, 1'b1, 1'b0);
        end
        q  = a / b;
        r  = a % b;
        ov = 1'b0;
`ifdef DSP_DIV_ROUND_EN
        ab = (b < 64'sd0) ? -b : b;
        ar = (r < 64'sd0) ? -r : r;
        if (64'sd2 * ar >= ab) begin
            q = ((a < 64'sd0) != (b < 64'sd0)) ? q - 64'sd1 : q + 64'sd1;
            r = a - q * b;
        end
`endif
        if (q > QMAX) begin
            q = QMAX; r = 64'sd0; ov = 1'b1;
        end else if (q < QMIN) begin
            q = QMIN; r = 64'sd0; ov = 1'b1;
        end
        return mk(q, r, 1'b0, ov);
    endfunction

    task automatic send(input longint a, input longint b, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", 64'(in_ready), 64'd1);
        dividend = a[DW-1:0];
        divisor  = b[VW-1:0];
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = DW'({$urandom(), $urandom()});
        divisor  = VW'($urandom());
    endtask

    // Latency n counts edges after the accept edge: out_valid appears on edge DW+1,
    // i.e. the (DW+2)th edge counting the accept edge itself.
    task automatic recv(input string tag, input int hold);
        int            n;
        exp_t          e;
        logic [DW-1:0] q0;
        logic [VW-1:0] r0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(DW + 1));
        chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e = '0;
        end
        chk({tag, "_quotient"}, 64'(quotient), 64'(e.q));
        chk({tag, "_remainder"}, 64'(remainder), 64'(e.r));
        chk({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e.ov));
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = DW'(i + 5);
            divisor  = VW'(3);
            @(negedge clk);
            chk({tag, "_hold_q"}, 64'(quotient), 64'(q0));
            chk({tag, "_hold_r"}, 64'(remainder), 64'(r0));
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        chk({tag, "_idle_stays"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint        a;
        longint        b;
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        send(64'sd100, 64'sd7, mk(64'sd14, 64'sd2, 1'b0, 1'b0));
        recv("p100_7", 0);
        send(-64'sd100, 64'sd7, mk(-64'sd14, -64'sd2, 1'b0, 1'b0));
        recv("n100_7", 0);
        send(64'sd100, -64'sd7, mk(-64'sd14, 64'sd2, 1'b0, 1'b0));
        recv("p100_n7", 0);
`ifdef DSP_DIV_ROUND_EN
        send(64'sd100, 64'sd8, mk(64'sd13, -64'sd4, 1'b0, 1'b0));
`else
        send(64'sd100, 64'sd8, mk(64'sd12, 64'sd4, 1'b0, 1'b0));
`endif
        recv("p100_8", 0);
        send(64'sd1234, 64'sd0, mk(QMAX, 64'sd0, 1'b1, 1'b0));
        recv("div0_pos", 0);
        send(-64'sd5, 64'sd0, mk(QMIN, 64'sd0, 1'b1, 1'b0));
        recv("div0_neg", 0);
        send(QMIN, -64'sd1, mk(QMAX, 64'sd0, 1'b0, 1'b1));
        recv("min_n1_ovf", 0);
        send(QMIN, 64'sd1, mk(QMIN, 64'sd0, 1'b0, 1'b0));
        recv("min_p1", 0);
        send(QMAX, -64'sd1, mk(-QMAX, 64'sd0, 1'b0, 1'b0));
        recv("max_n1", 0);
        send(QMIN, -64'sd131072, mk(64'sd1073741824, 64'sd0, 1'b0, 1'b0));
        recv("min_vmin", 0);

        out_ready = 1'b0;
        send(64'sd77, -64'sd5, mk(-64'sd15, 64'sd2, 1'b0, 1'b0));
        recv("backpressure", 20);

        send(64'sd1000, 64'sd3, mk(64'sd333, 64'sd1, 1'b0, 1'b0));
        repeat (10) @(negedge clk);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_quotient", 64'(quotient), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (55) @(negedge clk);
        chk("midrst_discarded", 64'(out_valid), 64'd0);
        send(64'sd48, 64'sd6, mk(64'sd8, 64'sd0, 1'b0, 1'b0));
        recv("after_rst", 0);

        for (int i = 0; i < 6; i++) begin
            ra = DW'({$urandom(), $urandom()}) >> (i * 7);
            rb = VW'($urandom()) >> i;
            if (rb == {VW{1'b0}}) begin
                rb = {{(VW-1){1'b0}}, 1'b1};
            end
            a = longint'($signed(ra));
            b = longint'($signed(rb));
            send(a, b, model(a, b));
            recv("rand", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
